// File: rtl/full_adder_pkg.sv
// Shared definitions for the full_adder family: width limit and the carry
// majority function used by every carry-generation variant.
package full_adder_pkg;

    localparam int FA_MAX_WIDTH = 64;

    function automatic logic fa_majority(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/fa_cell.sv
// Purely combinational 1-bit full adder cell; the building block of the
// ripple chain in full_adder.
module fa_cell
    import full_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = fa_majority(a, b, ci);

endmodule

// File: rtl/full_adder.sv
// Registered WIDTH-bit ripple-carry adder with a one-cycle valid pipeline.
// Define FULL_ADDER_OVF_EN to add a registered signed-overflow output ovf.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             in_vld,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_vld
`ifdef FULL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sumRaw;

    logic [WIDTH-1:0] sum_q,  sum_d;
    logic             cout_q, cout_d;
    logic             vld_q,  vld_d;

    assign carry[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        fa_cell u_cell (
            .a  (a[i]),
            .b  (b[i]),
            .ci (carry[i]),
            .s  (sumRaw[i]),
            .co (carry[i+1])
        );
    end

    // Results only load on a valid sample, so idle inputs never reach the outputs.
    always_comb begin
        sum_d  = sum_q;
        cout_d = cout_q;
        vld_d  = in_vld;
        if (in_vld) begin
            sum_d  = sumRaw;
            cout_d = carry[WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            vld_q  <= vld_d;
        end
    end

    assign sum     = sum_q;
    assign cout    = cout_q;
    assign out_vld = vld_q;

`ifdef FULL_ADDER_OVF_EN
    logic ovf_q, ovf_d;

    // Signed overflow: carry into the sign bit differs from carry out of it.
    always_comb begin
        ovf_d = ovf_q;
        if (in_vld) begin
            ovf_d = carry[WIDTH] ^ carry[WIDTH-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder: a 1-bit and an 8-bit instance checked
// against an arithmetic reference model plus hand-computed literal vectors.
module tb_full_adder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic [0:0] a1 = '0, b1 = '0;
    logic       cin1 = 1'b0, vld1 = 1'b0;
    logic [0:0] sum1;
    logic       cout1, outVld1;

    logic [7:0] a8 = '0, b8 = '0;
    logic       cin8 = 1'b0, vld8 = 1'b0;
    logic [7:0] sum8;
    logic       cout8, outVld8;

`ifdef FULL_ADDER_OVF_EN
    logic       ovf1, ovf8;
`endif

    int nVectors = 0;
    int nMiscompares = 0;

    // Reference model state (expected registered outputs)
    logic [0:0] expSum1;
    logic       expCout1, expVld1, expOvf1;
    logic [7:0] expSum8;
    logic       expCout8, expVld8, expOvf8;

    always #5 clk = ~clk;

    full_adder #(.WIDTH(1)) dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a1),
        .b       (b1),
        .cin     (cin1),
        .in_vld  (vld1),
        .sum     (sum1),
        .cout    (cout1),
        .out_vld (outVld1)
`ifdef FULL_ADDER_OVF_EN
        ,
        .ovf     (ovf1)
`endif
    );

    full_adder #(.WIDTH(8)) dut8 (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a8),
        .b       (b8),
        .cin     (cin8),
        .in_vld  (vld8),
        .sum     (sum8),
        .cout    (cout8),
        .out_vld (outVld8)
`ifdef FULL_ADDER_OVF_EN
        ,
        .ovf     (ovf8)
`endif
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nVectors++;
        if (actual !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus1(input logic va, input logic vb, input logic vc, input logic vv);
        a1 = va; b1 = vb; cin1 = vc; vld1 = vv;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus8(input logic [7:0] va, input logic [7:0] vb, input logic vc, input logic vv);
        a8 = va; b8 = vb; cin8 = vc; vld8 = vv;
        @(posedge clk);
        #1;
    endtask

    // Model: exact integer addition and signed-range test, updated on each valid sample
    always @(posedge clk or negedge rst_n) begin
        int total, sTotal;
        if (!rst_n) begin
            expSum1 = '0; expCout1 = 1'b0; expVld1 = 1'b0; expOvf1 = 1'b0;
            expSum8 = '0; expCout8 = 1'b0; expVld8 = 1'b0; expOvf8 = 1'b0;
        end else begin
            expVld1 = vld1;
            if (vld1) begin
                total    = int'(a1) + int'(b1) + int'(cin1);
                sTotal   = int'($signed(a1)) + int'($signed(b1)) + int'(cin1);
                expSum1  = total[0:0];
                expCout1 = (total >= 2);
                expOvf1  = (sTotal < -1) || (sTotal > 0);
            end
            expVld8 = vld8;
            if (vld8) begin
                total    = int'(a8) + int'(b8) + int'(cin8);
                sTotal   = int'($signed(a8)) + int'($signed(b8)) + int'(cin8);
                expSum8  = total[7:0];
                expCout8 = (total >= 256);
                expOvf8  = (sTotal < -128) || (sTotal > 127);
            end
        end
    end

    // Compare every output of both instances against the model on each falling edge
    always @(negedge clk) begin
        checkOutput("w1_sum",  64'(sum1),    64'(expSum1));
        checkOutput("w1_cout", 64'(cout1),   64'(expCout1));
        checkOutput("w1_vld",  64'(outVld1), 64'(expVld1));
        checkOutput("w8_sum",  64'(sum8),    64'(expSum8));
        checkOutput("w8_cout", 64'(cout8),   64'(expCout8));
        checkOutput("w8_vld",  64'(outVld8), 64'(expVld8));
`ifdef FULL_ADDER_OVF_EN
        checkOutput("w1_ovf",  64'(ovf1),    64'(expOvf1));
        checkOutput("w8_ovf",  64'(ovf8),    64'(expOvf8));
`endif
    end

    initial begin
        logic [1:0] truthExp [8];
        logic [2:0] bits;
        truthExp = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_sum8", 64'(sum8),    64'h0);
        checkOutput("reset_cout8", 64'(cout8),  64'h0);
        checkOutput("reset_vld8", 64'(outVld8), 64'h0);
        checkOutput("reset_vld1", 64'(outVld1), 64'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            bits = 3'(i);
            applyStimulus1(bits[2], bits[1], bits[0], 1'b1);
            checkOutput($sformatf("truth_%0d", i), 64'({cout1, sum1}), 64'(truthExp[i]));
            checkOutput($sformatf("truth_vld_%0d", i), 64'(outVld1), 64'h1);
        end

        applyStimulus1(1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("hold_load", 64'({cout1, sum1, outVld1}), 64'b101);
        applyStimulus1(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("hold_keep", 64'({cout1, sum1, outVld1}), 64'b100);
        applyStimulus1(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("hold_keep2", 64'({cout1, sum1, outVld1}), 64'b100);

        applyStimulus8(8'hFF, 8'hFF, 1'b1, 1'b1);
        checkOutput("ext_ff_ff_1", 64'({cout8, sum8}), 64'h1FF);
        applyStimulus8(8'hFF, 8'h00, 1'b1, 1'b1);
        checkOutput("ext_ff_00_1", 64'({cout8, sum8}), 64'h100);
        applyStimulus8(8'h00, 8'h00, 1'b0, 1'b1);
        checkOutput("ext_00_00_0", 64'({cout8, sum8}), 64'h000);
        applyStimulus8(8'h7F, 8'h01, 1'b0, 1'b1);
        checkOutput("ext_7f_01_0", 64'({cout8, sum8}), 64'h080);
`ifdef FULL_ADDER_OVF_EN
        checkOutput("ovf_7f_01", 64'(ovf8), 64'h1);
`endif
        applyStimulus8(8'h80, 8'h80, 1'b0, 1'b1);
        checkOutput("ext_80_80_0", 64'({cout8, sum8}), 64'h100);
`ifdef FULL_ADDER_OVF_EN
        checkOutput("ovf_80_80", 64'(ovf8), 64'h1);
`endif
        applyStimulus8(8'h01, 8'h01, 1'b0, 1'b1);
        checkOutput("ext_01_01_0", 64'({cout8, sum8}), 64'h002);
`ifdef FULL_ADDER_OVF_EN
        checkOutput("ovf_01_01", 64'(ovf8), 64'h0);
`endif

        for (int i = 0; i < 1000; i++) begin
            applyStimulus8(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
        end

        // Async reset mid-cycle while valid results are streaming
        applyStimulus8(8'hA5, 8'h5A, 1'b1, 1'b1);
        checkOutput("pre_reset_out", 64'({outVld8, cout8, sum8}), 64'h300);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_sum", 64'(sum8),    64'h0);
        checkOutput("async_rst_cout", 64'(cout8),  64'h0);
        checkOutput("async_rst_vld", 64'(outVld8), 64'h0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus8(8'h10, 8'h20, 1'b1, 1'b1);
        checkOutput("post_reset_first", 64'({outVld8, cout8, sum8}), 64'h231);
        applyStimulus8(8'h00, 8'h00, 1'b0, 1'b0);
        checkOutput("post_reset_idle", 64'({outVld8, cout8, sum8}), 64'h031);

        repeat (2) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
